reaction_timer: RTL and testbench

REACTION_TIMER -- requirements
Module: reaction_timer

---
 rtl/reaction_timer_pkg.sv | 26 ++
 rtl/lfsr16.sv | 25 ++
 rtl/reaction_timer.sv | 115 +++++++++++
 tb/tb_reaction_timer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/reaction_timer_pkg.sv
// Shared game parameters for the reaction timer: defaults, FSM encoding and LFSR taps.
package reaction_timer_pkg;

    // Default build values: 50 MHz clock gives a 1 ms tick at 50000 cycles.
    localparam int unsigned DefTickDiv  = 50000;
    localparam int unsigned DefMinDelay = 1000;
    localparam logic [15:0] DefLfsrSeed = 16'hACE1;

    // Fibonacci taps 16,14,13,11 expressed as a mask over bit indices 15,13,12,10.
    localparam logic [15:0] LfsrTapMask = 16'hB400;

    // Saturation value of the 13-bit score counter.
    localparam logic [12:0] ScoreMax = 13'h1FFF;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCount = 2'd1,
        StDone  = 2'd2
    } delay_state_e;

    // XOR of the tapped bits; this bit is shifted into the LSB.
    function automatic logic lfsr_feedback(input logic [15:0] state);
        return ^(state & LfsrTapMask);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, free-running on every non-reset cycle.
module lfsr16
    import reaction_timer_pkg::*;
#(
    parameter logic [15:0] SEED = DefLfsrSeed
) (
    input  logic        Clock,
    input  logic        CLRN,
    output logic [15:0] q
);

    logic [15:0] r_state;

    // Shift left each cycle; a nonzero seed keeps the sequence off the all-zero lockup state.
    always_ff @(posedge Clock) begin
        if (!CLRN) begin
            r_state <= SEED;
        end else begin
            r_state <= {r_state[14:0], lfsr_feedback(r_state)};
        end
    end

    assign q = r_state;

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: random-delay countdown FSM plus a saturating ms score counter.
module reaction_timer
    import reaction_timer_pkg::*;
#(
    parameter int unsigned TICK_DIV  = DefTickDiv,
    parameter int unsigned MIN_DELAY = DefMinDelay,
    parameter logic [15:0] LFSR_SEED = DefLfsrSeed
) (
    input  logic        Clock,
    input  logic        CLRN,
    input  logic        delayCounterEnable,
    input  logic        scoreCounterEnable,
    input  logic        scoreClear,
    output logic        delayCounterDone,
    output logic [12:0] scoreCounter,
    output logic [12:0] lastDelay
);

    localparam logic [15:0] TickLast    = 16'(TICK_DIV - 1);
    localparam logic [12:0] MinDelayVal = 13'(MIN_DELAY);

    logic [15:0]  w_lfsr;
    logic [12:0]  w_load_delay;
    logic         w_unused_lfsr_hi;

    delay_state_e r_state;
    logic         r_done;
    logic [12:0]  r_last_delay;
    logic [12:0]  r_remaining;
    logic [15:0]  r_dly_presc;

    logic [12:0]  r_score;
    logic [15:0]  r_score_presc;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .Clock (Clock),
        .CLRN  (CLRN),
        .q     (w_lfsr)
    );

    // Only the low 10 bits feed the delay; the rest just keep the sequence long.
    assign w_unused_lfsr_hi = ^w_lfsr[15:10];
    assign w_load_delay     = MinDelayVal + {3'b000, w_lfsr[9:0]};

    // Delay FSM: load in IDLE, count ms ticks in COUNT (pausable), one-cycle DONE pulse.
    always_ff @(posedge Clock) begin
        if (!CLRN) begin
            r_state      <= StIdle;
            r_done       <= 1'b0;
            r_last_delay <= 13'd0;
            r_remaining  <= 13'd0;
            r_dly_presc  <= 16'd0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (delayCounterEnable) begin
                        r_remaining  <= w_load_delay;
                        r_last_delay <= w_load_delay;
                        r_dly_presc  <= 16'd0;
                        r_state      <= StCount;
                    end
                end
                StCount: begin
                    // Dropping enable here pauses the countdown rather than aborting it.
                    if (delayCounterEnable) begin
                        if (r_dly_presc == TickLast) begin
                            r_dly_presc <= 16'd0;
                            r_remaining <= r_remaining - 13'd1;
                            if (r_remaining == 13'd1) begin
                                r_state <= StDone;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_dly_presc <= r_dly_presc + 16'd1;
                        end
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    // Score path: clear beats enable; the ms count sticks at full scale.
    always_ff @(posedge Clock) begin
        if (!CLRN) begin
            r_score       <= 13'd0;
            r_score_presc <= 16'd0;
        end else if (scoreClear) begin
            r_score       <= 13'd0;
            r_score_presc <= 16'd0;
        end else if (scoreCounterEnable) begin
            if (r_score_presc == TickLast) begin
                r_score_presc <= 16'd0;
                if (r_score != ScoreMax) begin
                    r_score <= r_score + 13'd1;
                end
            end else begin
                r_score_presc <= r_score_presc + 16'd1;
            end
        end
    end

    assign delayCounterDone = r_done;
    assign scoreCounter     = r_score;
    assign lastDelay        = r_last_delay;

endmodule

// File: tb/tb_reaction_timer.sv
// Directed self-checking bench for reaction_timer with TICK_DIV=4, MIN_DELAY=2.
module tb_reaction_timer;

    localparam int unsigned TickDiv  = 4;
    localparam int unsigned MinDelay = 2;
    localparam logic [15:0] Seed     = 16'hACE1;

    // Seed low 10 bits are 0x0E1 = 225, so the first load after reset is 2 + 225.
    localparam int FirstDelay = 227;

    logic        Clock;
    logic        CLRN;
    logic        delayCounterEnable;
    logic        scoreCounterEnable;
    logic        scoreClear;
    logic        delayCounterDone;
    logic [12:0] scoreCounter;
    logic [12:0] lastDelay;

    int          n_checks;
    int          n_pass;
    logic [15:0] m_lfsr;
    logic [15:0] m_pre;

    reaction_timer #(
        .TICK_DIV  (TickDiv),
        .MIN_DELAY (MinDelay),
        .LFSR_SEED (Seed)
    ) dut (
        .Clock              (Clock),
        .CLRN               (CLRN),
        .delayCounterEnable (delayCounterEnable),
        .scoreCounterEnable (scoreCounterEnable),
        .scoreClear         (scoreClear),
        .delayCounterDone   (delayCounterDone),
        .scoreCounter       (scoreCounter),
        .lastDelay          (lastDelay)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference LFSR step: taps at positions 16,14,13,11 feed the new LSB.
    function automatic logic [15:0] model_next(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One clock edge; the reference LFSR tracks the DUT, m_pre holds the value seen at that edge.
    task automatic step();
        @(posedge Clock);
        m_pre  = m_lfsr;
        m_lfsr = CLRN ? model_next(m_lfsr) : Seed;
        #1;
    endtask

    task automatic wait_done(input int bound, output int n);
        n = 0;
        while (!delayCounterDone && n < bound) begin
            step();
            n++;
        end
    endtask

    int n;
    int m;
    int d;

    initial begin
        n_checks           = 0;
        n_pass             = 0;
        m_lfsr             = Seed;
        m_pre              = Seed;
        CLRN               = 1'b0;
        delayCounterEnable = 1'b1;
        scoreCounterEnable = 1'b0;
        scoreClear         = 1'b0;

        // Reset state
        step();
        step();
        check_eq("reset done", int'(delayCounterDone), 0);
        check_eq("reset score", int'(scoreCounter), 0);
        check_eq("reset lastDelay", int'(lastDelay), 0);

        // First load uses the seed directly
        CLRN = 1'b1;
        step();
        check_eq("first lastDelay", int'(lastDelay), FirstDelay);
        check_eq("first done low", int'(delayCounterDone), 0);
        wait_done(4 * FirstDelay + 50, n);
        check_eq("first done latency", n, 4 * FirstDelay);
        step();
        check_eq("done one cycle", int'(delayCounterDone), 0);

        // Back-to-back load: IDLE lasts one cycle, so the load edge is the very next one
        step();
        d = int'(MinDelay) + int'(m_pre[9:0]);
        check_eq("second lastDelay", int'(lastDelay), d);
        check_eq("second range", int'(lastDelay >= 13'd2 && lastDelay <= 13'd1025), 1);
        wait_done(4 * d + 50, n);
        check_eq("second done latency", n, 4 * d);

        // Pause: 7 cycles with enable low mid-COUNT delay the pulse by 7
        step();
        check_eq("idle after second", int'(delayCounterDone), 0);
        step();
        d = int'(MinDelay) + int'(m_pre[9:0]);
        check_eq("third lastDelay", int'(lastDelay), d);
        repeat (5) step();
        delayCounterEnable = 1'b0;
        repeat (7) step();
        check_eq("no done in pause", int'(delayCounterDone), 0);
        check_eq("lastDelay held in pause", int'(lastDelay), d);
        delayCounterEnable = 1'b1;
        wait_done(4 * d + 50, m);
        check_eq("paused done latency", 12 + m, 4 * d + 7);
        delayCounterEnable = 1'b0;
        step();

        // Score counting, then hold
        scoreClear = 1'b1;
        step();
        check_eq("score cleared", int'(scoreCounter), 0);
        scoreClear         = 1'b0;
        scoreCounterEnable = 1'b1;
        repeat (39) step();
        check_eq("score 39 cycles", int'(scoreCounter), 9);
        step();
        check_eq("score 40 cycles", int'(scoreCounter), 10);
        scoreCounterEnable = 1'b0;
        repeat (10) step();
        check_eq("score hold", int'(scoreCounter), 10);

        // Saturation at 8191 and clear overriding enable
        scoreClear = 1'b1;
        step();
        scoreClear         = 1'b0;
        scoreCounterEnable = 1'b1;
        repeat (4 * 8191 - 1) step();
        check_eq("score before sat", int'(scoreCounter), 8190);
        step();
        check_eq("score at sat", int'(scoreCounter), 8191);
        repeat (4 * 8200 - 4 * 8191) step();
        check_eq("score saturated", int'(scoreCounter), 8191);
        scoreClear = 1'b1;
        step();
        check_eq("clear beats enable", int'(scoreCounter), 0);
        scoreClear = 1'b0;
        step();
        check_eq("score after clear", int'(scoreCounter), 0);
        scoreCounterEnable = 1'b0;

        // Abort: reset mid-COUNT, with score and delay both active
        delayCounterEnable = 1'b1;
        scoreCounterEnable = 1'b1;
        step();
        d = int'(MinDelay) + int'(m_pre[9:0]);
        check_eq("abort lastDelay", int'(lastDelay), d);
        repeat (5) step();
        check_eq("score concurrent", int'(scoreCounter), 1);
        CLRN = 1'b0;
        step();
        check_eq("abort done", int'(delayCounterDone), 0);
        check_eq("abort score", int'(scoreCounter), 0);
        check_eq("abort lastDelay zero", int'(lastDelay), 0);
        CLRN               = 1'b1;
        scoreCounterEnable = 1'b0;
        step();
        check_eq("reload after abort", int'(lastDelay), FirstDelay);
        wait_done(4 * FirstDelay + 50, n);
        check_eq("no stale done after abort", n, 4 * FirstDelay);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
